id_ex_pipe_reg: RTL

Parametrised ID/EX pipeline register for the 5-stage MIPS datapath. It replaces the free-running ID/EX latch with four additions:
- synchronous reset
- stall (hold)
- flush (bubble insertion)
- a valid bit per slot

It also contains load-use hazard detection that inserts a bubble itself and requests an upstream stall. A saturating counter of inserted load-use bubbles is kept for performance measurement.

---
 rtl/pipe_pkg.sv | 45 ++++
 rtl/load_use_detect.sv | 24 ++
 rtl/id_ex_pipe_reg.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, ALU-op encodings and control bundle for the MIPS pipeline
//
// Purpose: common types and constants imported by the pipeline-register slice.
// Contents: default DATA_W / REG_W / ALUOP_W, ALU-op encodings, packed
//           WB/M/EX control bundle and the all-zero BUBBLE bundle.
package pipe_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int ALUOP_W = 3;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;

    typedef struct packed {
        logic branch;
        logic mem_write;
        logic mem_read;
    } m_ctrl_t;

    typedef struct packed {
        logic reg_dst;
        logic alu_src;
    } ex_ctrl_t;

    // ALU op is kept outside the bundle because its width is a top-level parameter.
    typedef struct packed {
        wb_ctrl_t wb;
        m_ctrl_t  m;
        ex_ctrl_t ex;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector
//
// Purpose: flags when the instruction in ID reads a register that the load
//          currently in EX has not yet produced.
// Ports:   ex_valid, ex_mem_read, ex_rt  - load in EX (ID/EX register outputs)
//          id_valid, id_rs, id_rt        - instruction being decoded
//          hz                            - hazard present
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hz
);

    // $0 is hard-wired to zero, so a load targeting it never produces a dependency.
    assign hz = ex_valid & ex_mem_read & id_valid & (ex_rt != '0)
              & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with reset, hold, flush, valid and load-use bubbles
//
// Purpose: registers ID-stage controls and operands for EX; inserts a bubble on
//          flush or on a load-use hazard and counts load-use bubbles (saturating).
// Ports:   clk, rst (sync, active-high), en (0 = hold), flush (load bubble)
//          in_*  - ID-stage valid, controls, data and register fields
//          out_* - registered copies of in_*
//          stall_o    - combinational load-use stall request to PC / IF-ID
//          bubble_cnt - saturating count of load-use bubbles
module id_ex_pipe_reg #(
    parameter int DATA_W  = pipe_pkg::DATA_W,
    parameter int REG_W   = pipe_pkg::REG_W,
    parameter int ALUOP_W = pipe_pkg::ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic               in_valid,
    input  logic               in_mem_to_reg,
    input  logic               in_reg_write,
    input  logic               in_branch,
    input  logic               in_mem_write,
    input  logic               in_mem_read,
    input  logic               in_reg_dst,
    input  logic               in_alu_src,
    input  logic [ALUOP_W-1:0] in_alu_op,
    input  logic [DATA_W-1:0]  in_pc4,
    input  logic [DATA_W-1:0]  in_rd1,
    input  logic [DATA_W-1:0]  in_rd2,
    input  logic [DATA_W-1:0]  in_sext,
    input  logic [REG_W-1:0]   in_rs,
    input  logic [REG_W-1:0]   in_rt,
    input  logic [REG_W-1:0]   in_rd,
    output logic               out_valid,
    output logic               out_mem_to_reg,
    output logic               out_reg_write,
    output logic               out_branch,
    output logic               out_mem_write,
    output logic               out_mem_read,
    output logic               out_reg_dst,
    output logic               out_alu_src,
    output logic [ALUOP_W-1:0] out_alu_op,
    output logic [DATA_W-1:0]  out_pc4,
    output logic [DATA_W-1:0]  out_rd1,
    output logic [DATA_W-1:0]  out_rd2,
    output logic [DATA_W-1:0]  out_sext,
    output logic [REG_W-1:0]   out_rs,
    output logic [REG_W-1:0]   out_rt,
    output logic [REG_W-1:0]   out_rd,
    output logic               stall_o,
    output logic [CNT_W-1:0]   bubble_cnt
);

    import pipe_pkg::*;

    ctrl_t              ctrl_in;
    ctrl_t              ctrl_q;
    logic               valid_q;
    logic [ALUOP_W-1:0] alu_op_q;
    logic [DATA_W-1:0]  pc4_q;
    logic [DATA_W-1:0]  rd1_q;
    logic [DATA_W-1:0]  rd2_q;
    logic [DATA_W-1:0]  sext_q;
    logic [REG_W-1:0]   rs_q;
    logic [REG_W-1:0]   rt_q;
    logic [REG_W-1:0]   rd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               hz;
    logic               load_bubble;
    logic               count_bubble;

    assign ctrl_in.wb.mem_to_reg = in_mem_to_reg;
    assign ctrl_in.wb.reg_write  = in_reg_write;
    assign ctrl_in.m.branch      = in_branch;
    assign ctrl_in.m.mem_write   = in_mem_write;
    assign ctrl_in.m.mem_read    = in_mem_read;
    assign ctrl_in.ex.reg_dst    = in_reg_dst;
    assign ctrl_in.ex.alu_src    = in_alu_src;

    load_use_detect #(
        .REG_W(REG_W)
    ) u_load_use_detect (
        .ex_valid   (valid_q),
        .ex_mem_read(ctrl_q.m.mem_read),
        .ex_rt      (rt_q),
        .id_valid   (in_valid),
        .id_rs      (in_rs),
        .id_rt      (in_rt),
        .hz         (hz)
    );

    assign stall_o = hz & ~rst;

    // Reset and flush override a hold; a load-use bubble only happens when the
    // stage is allowed to advance, so a held hazard is counted once, on release.
    assign load_bubble  = rst | flush | (en & hz);
    assign count_bubble = ~flush & en & hz;

    always_ff @(posedge clk) begin
        if (load_bubble) begin
            valid_q  <= 1'b0;
            ctrl_q   <= BUBBLE;
            alu_op_q <= '0;
            pc4_q    <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            sext_q   <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
        end else if (en) begin
            valid_q  <= in_valid;
            ctrl_q   <= ctrl_in;
            alu_op_q <= in_alu_op;
            pc4_q    <= in_pc4;
            rd1_q    <= in_rd1;
            rd2_q    <= in_rd2;
            sext_q   <= in_sext;
            rs_q     <= in_rs;
            rt_q     <= in_rt;
            rd_q     <= in_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (count_bubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid      = valid_q;
    assign out_mem_to_reg = ctrl_q.wb.mem_to_reg;
    assign out_reg_write  = ctrl_q.wb.reg_write;
    assign out_branch     = ctrl_q.m.branch;
    assign out_mem_write  = ctrl_q.m.mem_write;
    assign out_mem_read   = ctrl_q.m.mem_read;
    assign out_reg_dst    = ctrl_q.ex.reg_dst;
    assign out_alu_src    = ctrl_q.ex.alu_src;
    assign out_alu_op     = alu_op_q;
    assign out_pc4        = pc4_q;
    assign out_rd1        = rd1_q;
    assign out_rd2        = rd2_q;
    assign out_sext       = sext_q;
    assign out_rs         = rs_q;
    assign out_rt         = rt_q;
    assign out_rd         = rd_q;
    assign bubble_cnt     = cnt_q;

endmodule
